// File: rtl/int_div_unit_if.sv
// Issue/writeback port bundle for the iterative integer divider.
// Both sides use valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge, and ready may depend combinationally on the receiver's state.
interface int_div_unit_if #(
  parameter int XLEN          = 32,
  parameter int ROB_IDX_WIDTH = 6,
  parameter int PREG_WIDTH    = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_op;
  logic                     in_word;
  logic [XLEN-1:0]          in_rs1;
  logic [XLEN-1:0]          in_rs2;
  logic [ROB_IDX_WIDTH-1:0] in_rob_idx;
  logic [PREG_WIDTH-1:0]    in_rd;
  logic                     in_we;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_res;
  logic [ROB_IDX_WIDTH-1:0] out_rob_idx;
  logic [PREG_WIDTH-1:0]    out_rd;
  logic                     out_we;
  logic [2:0]               dbg_state;

  modport master (
    output in_valid, in_op, in_word, in_rs1, in_rs2, in_rob_idx, in_rd, in_we, flush, out_ready,
    input  in_ready, out_valid, out_res, out_rob_idx, out_rd, out_we, dbg_state
  );

  modport slave (
    input  in_valid, in_op, in_word, in_rs1, in_rs2, in_rob_idx, in_rd, in_we, flush, out_ready,
    output in_ready, out_valid, out_res, out_rob_idx, out_rd, out_we, dbg_state
  );
endinterface

// File: rtl/int_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU (and optional word forms),
// retiring RADIX_BITS quotient bits per ITER cycle; divide-by-zero and overflow finish from PRE.
module int_div_unit #(
  parameter int XLEN          = 32,
  parameter int RADIX_BITS    = 1,
  parameter int WORD_SUPPORT  = 0,
  parameter int ROB_IDX_WIDTH = 6,
  parameter int PREG_WIDTH    = 7
) (
  input logic           clk,
  input logic           rst,
  int_div_unit_if.slave io
);

  localparam int RW    = XLEN + 2;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] K_FULL_M1 = CNT_W'(XLEN / RADIX_BITS - 1);
  localparam logic [CNT_W-1:0] K_WORD_M1 = CNT_W'(32 / RADIX_BITS - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] POST = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [1:0]               op_q;
  logic                     word_q;
  logic [XLEN-1:0]          a_q, b_q;
  logic [XLEN-1:0]          r_q, q_q, d_q;
  logic [RW-1:0]            d3_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     q_neg_q, r_neg_q;
  logic [XLEN-1:0]          res_q;
  logic [ROB_IDX_WIDTH-1:0] rob_q;
  logic [PREG_WIDTH-1:0]    rd_q;
  logic                     we_q;

  logic accept, out_hs;

  assign io.in_ready = ~io.flush & ((state_q == IDLE) | ((state_q == DONE) & io.out_ready));
  assign accept      = io.in_valid & io.in_ready;
  assign out_hs      = (state_q == DONE) & io.out_ready;

  assign io.out_valid   = (state_q == DONE);
  assign io.out_res     = res_q;
  assign io.out_rob_idx = rob_q;
  assign io.out_rd      = rd_q;
  assign io.out_we      = we_q;
  assign io.dbg_state   = state_q;

  // ---------------- PRE: operand conditioning and special cases ----------------
  logic            is_signed, s1, s2, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, q_init, div_word, spec_res;

  always_comb begin
    is_signed = ~op_q[0];
    if (word_q) begin
      a_ext = is_signed ? XLEN'($signed(a_q[31:0])) : XLEN'(a_q[31:0]);
      b_ext = is_signed ? XLEN'($signed(b_q[31:0])) : XLEN'(b_q[31:0]);
    end else begin
      a_ext = a_q;
      b_ext = b_q;
    end
    s1    = is_signed & a_ext[XLEN-1];
    s2    = is_signed & b_ext[XLEN-1];
    a_abs = s1 ? -a_ext : a_ext;
    b_abs = s2 ? -b_ext : b_ext;
    // Word dividends sit at the top of q so 32/RADIX_BITS shifts consume them exactly.
    q_init = word_q ? (a_abs << (XLEN - 32)) : a_abs;
    div0   = (b_ext == '0);
    if (word_q) ovf = is_signed & (a_q[31:0] == 32'h8000_0000) & (b_q[31:0] == 32'hFFFF_FFFF);
    else        ovf = is_signed & (a_q == MOST_NEG) & (b_q == ALL_ONES);
    div_word = word_q ? XLEN'($signed(a_q[31:0])) : a_q;
    if (div0) spec_res = op_q[1] ? div_word : ALL_ONES;
    else      spec_res = op_q[1] ? '0 : div_word;
  end

  // ---------------- ITER: one restoring step of RADIX_BITS bits ----------------
  logic [XLEN+RADIX_BITS-1:0] sh_cat;
  logic [RW-1:0]              sh, d1, d2, r_sub;
  logic [1:0]                 qbits;
  logic [XLEN-1:0]            q_next;

  always_comb begin
    sh_cat = {r_q, q_q[XLEN-1 -: RADIX_BITS]};
    sh     = RW'(sh_cat);
    d1     = RW'(d_q);
    d2     = RW'(d_q) << 1;
    qbits  = 2'b00;
    r_sub  = sh;
    if (RADIX_BITS == 2) begin
      if (sh >= d3_q) begin
        qbits = 2'b11;
        r_sub = sh - d3_q;
      end else if (sh >= d2) begin
        qbits = 2'b10;
        r_sub = sh - d2;
      end else if (sh >= d1) begin
        qbits = 2'b01;
        r_sub = sh - d1;
      end
    end else begin
      if (sh >= d1) begin
        qbits = 2'b01;
        r_sub = sh - d1;
      end
    end
    q_next = (q_q << RADIX_BITS) | XLEN'(qbits);
  end

  logic unused_bits;
  assign unused_bits = ^r_sub[RW-1:XLEN];

  // ---------------- POST: sign fix-up and result select ----------------
  logic [XLEN-1:0] q_fin, r_fin, sel, post_res;

  always_comb begin
    q_fin    = q_neg_q ? -q_q : q_q;
    r_fin    = r_neg_q ? -r_q : r_q;
    sel      = op_q[1] ? r_fin : q_fin;
    post_res = word_q ? XLEN'($signed(sel[31:0])) : sel;
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = PRE;
      PRE:  state_d = (div0 | ovf) ? DONE : ITER;
      ITER: if (cnt_q == '0) state_d = POST;
      POST: state_d = DONE;
      DONE: if (out_hs) state_d = accept ? PRE : IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      res_q   <= '0;
      rob_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= io.in_op;
        word_q <= (WORD_SUPPORT != 0) && (XLEN == 64) && io.in_word;
        a_q    <= io.in_rs1;
        b_q    <= io.in_rs2;
        rob_q  <= io.in_rob_idx;
        rd_q   <= io.in_rd;
        we_q   <= io.in_we;
      end
      case (state_q)
        PRE: begin
          r_q     <= '0;
          q_q     <= q_init;
          d_q     <= b_abs;
          d3_q    <= RW'(b_abs) + (RW'(b_abs) << 1);
          cnt_q   <= word_q ? K_WORD_M1 : K_FULL_M1;
          q_neg_q <= s1 ^ s2;
          r_neg_q <= s1;
          if (div0 | ovf) res_q <= spec_res;
        end
        ITER: begin
          r_q   <= r_sub[XLEN-1:0];
          q_q   <= q_next;
          cnt_q <= cnt_q - 1'b1;
        end
        POST:    res_q <= post_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_unit.sv
// Directed bench for int_div_unit: a 32-bit radix-2 (1 bit/cycle) instance and a
// 64-bit radix-4 (2 bits/cycle) instance with word support, sharing one clock.
module tb_int_div_unit;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;
  int   lat;

  int_div_unit_if #(.XLEN(32), .ROB_IDX_WIDTH(6), .PREG_WIDTH(7)) if32 ();
  int_div_unit_if #(.XLEN(64), .ROB_IDX_WIDTH(6), .PREG_WIDTH(7)) if64 ();

  int_div_unit #(.XLEN(32), .RADIX_BITS(1), .WORD_SUPPORT(0), .ROB_IDX_WIDTH(6), .PREG_WIDTH(7)) dut32 (
    .clk (clk),
    .rst (rst),
    .io  (if32)
  );

  int_div_unit #(.XLEN(64), .RADIX_BITS(2), .WORD_SUPPORT(1), .ROB_IDX_WIDTH(6), .PREG_WIDTH(7)) dut64 (
    .clk (clk),
    .rst (rst),
    .io  (if64)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] rob, input logic [6:0] rd);
    if32.in_valid   = 1'b1;
    if32.in_op      = op;
    if32.in_rs1     = a;
    if32.in_rs2     = b;
    if32.in_rob_idx = rob;
    if32.in_rd      = rd;
    if32.in_we      = 1'b1;
    @(negedge clk);
    check("in_ready32", 64'(if32.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
  endtask

  task automatic issue64(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] rob, input logic [6:0] rd);
    if64.in_valid   = 1'b1;
    if64.in_op      = op;
    if64.in_word    = word;
    if64.in_rs1     = a;
    if64.in_rs2     = b;
    if64.in_rob_idx = rob;
    if64.in_rd      = rd;
    if64.in_we      = 1'b1;
    @(negedge clk);
    check("in_ready64", 64'(if64.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    if64.in_word  = 1'b0;
  endtask

  // Returns cycles from accept to first out_valid (0 on timeout); leaves time at that negedge.
  task automatic wait32(output int l);
    l = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (if32.out_valid) begin
        l = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait64(output int l);
    l = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (if64.out_valid) begin
        l = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rises;
    n_asserts = 0;
    n_fail    = 0;
    rst = 1'b0;
    if32.in_valid = 1'b0; if32.in_op = 2'b00; if32.in_word = 1'b0; if32.in_rs1 = '0; if32.in_rs2 = '0;
    if32.in_rob_idx = '0; if32.in_rd = '0; if32.in_we = 1'b0; if32.flush = 1'b0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.in_op = 2'b00; if64.in_word = 1'b0; if64.in_rs1 = '0; if64.in_rs2 = '0;
    if64.in_rob_idx = '0; if64.in_rd = '0; if64.in_we = 1'b0; if64.flush = 1'b0; if64.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if32.out_valid), 64'd0);
    check("rst_out_res",   64'(if32.out_res), 64'd0);
    check("rst_out_tags",  64'({if32.out_rob_idx, if32.out_rd, if32.out_we}), 64'd0);
    check("rst_out_res64", if64.out_res, 64'd0);
    rst = 1'b1;
    step();
    check("rst_in_ready", 64'(if32.in_ready), 64'd1);
    check("rst_state",    64'(if32.dbg_state), 64'd0);

    // DIV / REM -7 / 2
    issue32(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd5, 7'd12);
    wait32(lat);
    check("div_lat",  64'(lat), 64'd35);
    check("div_res",  64'(if32.out_res), 64'hFFFF_FFFD);
    check("div_rob",  64'(if32.out_rob_idx), 64'd5);
    check("div_rd",   64'(if32.out_rd), 64'd12);
    check("div_we",   64'(if32.out_we), 64'd1);
    step();
    issue32(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd5, 7'd12);
    wait32(lat);
    check("rem_lat", 64'(lat), 64'd35);
    check("rem_res", 64'(if32.out_res), 64'hFFFF_FFFF);
    step();

    // Divide by zero
    issue32(2'b01, 32'd100, 32'd0, 6'd1, 7'd2);
    wait32(lat);
    check("divu0_lat", 64'(lat), 64'd2);
    check("divu0_res", 64'(if32.out_res), 64'hFFFF_FFFF);
    step();
    issue32(2'b11, 32'd100, 32'd0, 6'd1, 7'd2);
    wait32(lat);
    check("remu0_lat", 64'(lat), 64'd2);
    check("remu0_res", 64'(if32.out_res), 64'd100);
    step();

    // Signed overflow
    issue32(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3, 7'd4);
    wait32(lat);
    check("ovf_div_lat", 64'(lat), 64'd2);
    check("ovf_div_res", 64'(if32.out_res), 64'h8000_0000);
    step();
    issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3, 7'd4);
    wait32(lat);
    check("ovf_rem_lat", 64'(lat), 64'd2);
    check("ovf_rem_res", 64'(if32.out_res), 64'd0);
    step();

    // Backpressure, then back-to-back accept in DONE
    if32.out_ready = 1'b0;
    issue32(2'b01, 32'd1000, 32'd10, 6'd7, 7'd20);
    wait32(lat);
    check("bp_lat", 64'(lat), 64'd35);
    check("bp_res0", 64'(if32.out_res), 64'd100);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("bp_hold_valid", 64'(if32.out_valid), 64'd1);
      check("bp_hold_res",   64'(if32.out_res), 64'd100);
      check("bp_hold_rob",   64'(if32.out_rob_idx), 64'd7);
    end
    step();
    if32.out_ready = 1'b1;
    issue32(2'b00, 32'd17, 32'hFFFF_FFFB, 6'd8, 7'd21);
    wait32(lat);
    check("b2b_lat", 64'(lat), 64'd35);
    check("b2b_res", 64'(if32.out_res), 64'hFFFF_FFFD);
    check("b2b_rob", 64'(if32.out_rob_idx), 64'd8);
    check("b2b_rd",  64'(if32.out_rd), 64'd21);
    step();

    // Flush during the 10th ITER cycle
    issue32(2'b01, 32'd1000, 32'd3, 6'd9, 7'd22);
    repeat (10) step();
    @(negedge clk);
    check("flush_in_iter", 64'(if32.dbg_state), 64'd2);
    if32.flush = 1'b1;
    step();
    if32.flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(if32.in_ready), 64'd1);
    check("flush_idle",     64'(if32.dbg_state), 64'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (if32.out_valid) rises++;
    end
    check("flush_no_valid", 64'(rises), 64'd0);
    step();
    issue32(2'b01, 32'd50, 32'd7, 6'd10, 7'd23);
    wait32(lat);
    check("post_flush_lat", 64'(lat), 64'd35);
    check("post_flush_res", 64'(if32.out_res), 64'd7);
    step();

    // Reset mid-operation
    issue32(2'b00, 32'd99, 32'd9, 6'd11, 7'd24);
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("midrst_state", 64'(if32.dbg_state), 64'd0);
    check("midrst_res",   64'(if32.out_res), 64'd0);
    step();
    rst = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (if32.out_valid) rises++;
    end
    check("midrst_no_valid", 64'(rises), 64'd0);
    step();

    // 64-bit, 2 bits per cycle
    issue64(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'd12, 7'd30);
    wait64(lat);
    check("divu64_lat", 64'(lat), 64'd35);
    check("divu64_res", if64.out_res, 64'h5555_5555_5555_5555);
    check("divu64_rob", 64'(if64.out_rob_idx), 64'd12);
    step();
    issue64(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'd13, 7'd31);
    wait64(lat);
    check("div64_lat", 64'(lat), 64'd35);
    check("div64_res", if64.out_res, 64'hFFFF_FFFF_FFFF_FFF2);
    step();
    issue64(2'b00, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd3, 6'd14, 7'd32);
    wait64(lat);
    check("divw_lat", 64'(lat), 64'd19);
    check("divw_res", if64.out_res, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    issue64(2'b11, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd3, 6'd15, 7'd33);
    wait64(lat);
    check("remuw_lat", 64'(lat), 64'd19);
    check("remuw_res", if64.out_res, 64'd2);
    step();
    issue64(2'b01, 1'b1, 64'h1234_5678_0000_0064, 64'd0, 6'd16, 7'd34);
    wait64(lat);
    check("divuw0_lat", 64'(lat), 64'd2);
    check("divuw0_res", if64.out_res, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
